// File: rtl/qam_pkg.sv
// Shared types, the 16-QAM Gray level mapping and the transmit FSM state enum.
// Latency: none, types and a pure function only.
// Backpressure: not applicable.
package qam_pkg;

  localparam int Q_FRAC = 12;

  typedef logic [3:0]          qam_sym_t;
  typedef logic signed [17:0]  sample_t;

  typedef enum logic [1:0] {IDLE, RUN, UNDERRUN} tx_state_e;

  // Gray order along the axis: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3 (times amp).
  function automatic sample_t gray_dibit_to_level(input logic [1:0] dibit, input int amp);
    sample_t level;
    case (dibit)
      2'b00:   level = sample_t'(-3 * amp);
      2'b01:   level = sample_t'(-amp);
      2'b11:   level = sample_t'(amp);
      default: level = sample_t'(3 * amp);
    endcase
    return level;
  endfunction

endpackage

// File: rtl/qam_sym_fifo.sv
// Small synchronous FIFO holding 4-bit QAM symbols, head word read combinationally.
// Latency: a pushed symbol is visible at the head one cycle after the push edge.
// Backpressure: full is a decode of the registered count; pushes when full and pops when empty are ignored.
module qam_sym_fifo
  import qam_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  qam_sym_t push_dat,
  input  logic     pop,
  output qam_sym_t pop_dat,
  output logic     full,
  output logic     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  qam_sym_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/qam_tx_shaper.sv
// 16-QAM transmit source: buffers symbols, Gray-maps to 5Q12 I/Q, holds each for SPS samples.
// Latency: symbol pushed at t into an idle, empty shaper with tx_en high is on mod_i/mod_q at t+2.
// Backpressure: sym_ready is !full of the registered FIFO count; output stream is never stalled.
module qam_tx_shaper
  import qam_pkg::*;
#(
  parameter int SPS        = 20,
  parameter int AMP        = 1 << Q_FRAC,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        axi_clk,
  input  logic        axi_rstn,
  input  logic        tx_en,
  input  logic        sym_valid,
  output logic        sym_ready,
  input  logic [3:0]  sym_data,
  output logic        mod_valid,
  output logic [17:0] mod_i,
  output logic [17:0] mod_q,
  output logic        underflow,
  output logic        busy
);

  tx_state_e  state, state_n;
  logic [7:0] cnt, cnt_n;
  sample_t    i_n, q_n;
  logic       valid_n;
  logic       uf_n;
  logic       pop;
  logic       boundary;
  logic       fifo_full;
  logic       fifo_empty;
  qam_sym_t   head;

  qam_sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (axi_clk),
    .rst_n    (axi_rstn),
    .push     (sym_valid && sym_ready),
    .push_dat (sym_data),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign sym_ready = !fifo_full;
  assign busy      = (state != IDLE);
  assign boundary  = (state == IDLE) || (cnt == 8'(SPS - 1));

  // Next state and next output values; decisions are only taken at a symbol boundary.
  always_comb begin
    state_n = state;
    cnt_n   = boundary ? 8'd0 : cnt + 8'd1;
    i_n     = sample_t'(mod_i);
    q_n     = sample_t'(mod_q);
    valid_n = mod_valid;
    uf_n    = 1'b0;
    pop     = 1'b0;
    if (boundary) begin
      state_n = IDLE;
      i_n     = '0;
      q_n     = '0;
      valid_n = 1'b0;
      if (tx_en && !fifo_empty) begin
        pop     = 1'b1;
        i_n     = gray_dibit_to_level(head[3:2], AMP);
        q_n     = gray_dibit_to_level(head[1:0], AMP);
        valid_n = 1'b1;
        state_n = RUN;
      end else if (tx_en && state != IDLE) begin
        // Starved while transmitting: send a zero symbol to keep symbol timing.
        valid_n = 1'b1;
        uf_n    = 1'b1;
        state_n = UNDERRUN;
      end
    end
  end

  // State, sample counter and the registered output stream.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      mod_i     <= '0;
      mod_q     <= '0;
      mod_valid <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mod_i     <= i_n;
      mod_q     <= q_n;
      mod_valid <= valid_n;
      underflow <= uf_n;
    end
  end

endmodule

// File: tb/tb_qam_tx_shaper.sv
// Self-checking bench for qam_tx_shaper: directed steps plus random traffic vs. a queue-based model.
// Latency: model predicts each output cycle; outputs sampled 1 time unit after the rising edge.
// Backpressure: model tracks FIFO occupancy to predict sym_ready and which pushes are accepted.
module tb_qam_tx_shaper;

  localparam int SPS = 20;
  localparam int AMP = 4096;
  localparam int FD  = 4;

  logic        axi_clk;
  logic        axi_rstn;
  logic        tx_en;
  logic        sym_valid;
  logic        sym_ready;
  logic [3:0]  sym_data;
  logic        mod_valid;
  logic [17:0] mod_i;
  logic [17:0] mod_q;
  logic        underflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: symbol queue plus "samples left in the symbol being shown".
  logic [3:0] mq[$];
  int m_active;   // 0 idle, 1 data symbol, 2 zero symbol
  int m_left;
  int m_i, m_q, m_v, m_uf;
  bit m_acc;

  int tally_v, tally_uf, tally_hit;

  qam_tx_shaper #(.SPS(SPS), .AMP(AMP), .FIFO_DEPTH(FD)) dut (
    .axi_clk   (axi_clk),
    .axi_rstn  (axi_rstn),
    .tx_en     (tx_en),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_data  (sym_data),
    .mod_valid (mod_valid),
    .mod_i     (mod_i),
    .mod_q     (mod_q),
    .underflow (underflow),
    .busy      (busy)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Gray dibit -> axis index 0..3, then evenly spaced levels -3,-1,+1,+3 times AMP.
  function automatic int lvl(input logic [1:0] d);
    int idx;
    idx = 2 * int'(d[1]) + int'(d[1] ^ d[0]);
    return (2 * idx - 3) * AMP;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 0; m_left = 0;
    m_i = 0; m_q = 0; m_v = 0; m_uf = 0;
    m_acc = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic model_edge();
    bit rdy_before;
    logic [3:0] s;
    rdy_before = (mq.size() < FD);
    m_uf = 0;
    if (m_active != 0 && m_left > 1) begin
      m_left--;
    end else if (tx_en && mq.size() > 0) begin
      s = mq.pop_front();
      m_i = lvl(s[3:2]); m_q = lvl(s[1:0]);
      m_v = 1; m_active = 1; m_left = SPS;
    end else if (tx_en && m_active != 0) begin
      m_i = 0; m_q = 0; m_v = 1; m_uf = 1;
      m_active = 2; m_left = SPS;
    end else begin
      m_i = 0; m_q = 0; m_v = 0; m_active = 0; m_left = 0;
    end
    m_acc = sym_valid && rdy_before;
    if (m_acc) mq.push_back(sym_data);
  endtask

  task automatic step();
    @(posedge axi_clk);
    model_edge();
    #1;
    chk("mod_valid", int'(mod_valid), m_v);
    chk("mod_i", int'($signed(mod_i)), m_i);
    chk("mod_q", int'($signed(mod_q)), m_q);
    chk("underflow", int'(underflow), m_uf);
    chk("busy", int'(busy), (m_active != 0) ? 1 : 0);
    chk("sym_ready", int'(sym_ready), (mq.size() < FD) ? 1 : 0);
    tally_v  += int'(mod_valid);
    tally_uf += int'(underflow);
    if (mod_valid && $signed(mod_i) == 12288 && $signed(mod_q) == -4096) tally_hit++;
  endtask

  task automatic clr_tally();
    tally_v = 0; tally_uf = 0; tally_hit = 0;
  endtask

  initial begin
    int t;
    logic [3:0] stream [4];
    stream[0] = 4'b0000; stream[1] = 4'b0101; stream[2] = 4'b1111; stream[3] = 4'b1010;

    // Reset with tx_en already high and no symbols offered.
    axi_rstn = 1'b0; tx_en = 1'b1; sym_valid = 1'b0; sym_data = 4'h0;
    model_reset(); clr_tally();
    repeat (3) @(posedge axi_clk);
    #3 axi_rstn = 1'b1;
    #1;
    chk("rst_mod_valid", int'(mod_valid), 0);
    chk("rst_mod_i", int'(mod_i), 0);
    chk("rst_mod_q", int'(mod_q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_underflow", int'(underflow), 0);
    chk("rst_sym_ready", int'(sym_ready), 1);
    @(posedge axi_clk); #1;
    repeat (3) step();

    // Single symbol 1001, then one underflow and a zero symbol.
    clr_tally();
    sym_valid = 1'b1; sym_data = 4'b1001;
    step();
    sym_valid = 1'b0;
    repeat (40) step();
    chk("single_samples", tally_hit, 20);
    chk("single_valid", tally_v, 40);
    chk("single_uf", tally_uf, 1);
    tx_en = 1'b0;
    repeat (25) step();

    // Back-to-back stream of four symbols.
    tx_en = 1'b1; clr_tally();
    for (int k = 0; k < 4; k++) begin
      sym_valid = 1'b1; sym_data = stream[k];
      step();
    end
    sym_valid = 1'b0;
    repeat (77) step();
    chk("stream_valid", tally_v, 80);
    chk("stream_uf", tally_uf, 0);
    tx_en = 1'b0;
    repeat (25) step();

    // Backpressure: five symbols offered while disabled.
    tx_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sym_valid = 1'b1; sym_data = 4'($urandom);
      step();
      if (k == 3) chk("bp_ready_low", int'(sym_ready), 0);
    end
    chk("bp_fifth_held", int'(m_acc), 0);
    tx_en = 1'b1;
    t = 0;
    do begin
      step();
      t++;
    end while (!m_acc && t < 50);
    chk("bp_accept_cycle", t, 2);
    sym_valid = 1'b0;
    repeat (105) step();
    tx_en = 1'b0;
    repeat (25) step();

    // tx_en dropped at sample 7 of a symbol.
    tx_en = 1'b1; clr_tally();
    sym_valid = 1'b1; sym_data = 4'($urandom);
    step();
    sym_valid = 1'b0;
    repeat (8) step();
    tx_en = 1'b0;
    repeat (20) step();
    chk("drop_valid_count", tally_v, 20);
    chk("drop_busy", int'(busy), 0);
    chk("drop_mod_valid", int'(mod_valid), 0);

    // Asynchronous reset in the middle of a symbol with symbols still buffered.
    tx_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sym_valid = 1'b1; sym_data = 4'($urandom);
      step();
    end
    sym_valid = 1'b0;
    repeat (9) step();
    #2 axi_rstn = 1'b0;
    #1;
    chk("arst_mod_valid", int'(mod_valid), 0);
    chk("arst_mod_i", int'(mod_i), 0);
    chk("arst_mod_q", int'(mod_q), 0);
    chk("arst_busy", int'(busy), 0);
    model_reset();
    @(posedge axi_clk);
    @(posedge axi_clk);
    #3 axi_rstn = 1'b1;
    clr_tally();
    repeat (30) step();
    chk("arst_no_replay", tally_v, 0);

    // Random traffic: sparse symbols, occasional tx_en flips.
    for (int n = 0; n < 1500; n++) begin
      sym_valid = ($urandom_range(0, 14) == 0);
      sym_data  = 4'($urandom);
      if ($urandom_range(0, 59) == 0) tx_en = ~tx_en;
      step();
    end
    sym_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qam_tx_shaper.md
Name: qam_tx_shaper

Overview:
- Transmit-side baseband source for the 16-QAM link; the counterpart of the receive demodulate-and-filter path.
- Accepts 4-bit symbols over a valid/ready handshake and buffers them in a small FIFO.
- Gray-maps each symbol to I/Q levels in 5Q12 and holds each level for SPS clocks as a continuous sample stream.
- Output feeds the carrier multiplier (modulator) that sits ahead of the DAC.

Parameters:
- SPS, 20, samples per symbol; 100 MHz / 20 = 5 MBaud; legal range 2..255.
- AMP, 4096, unit level in 5Q12 (1.0); the ±3 level is 3*AMP.
- FIFO_DEPTH, 4, symbol buffer entries; power of two, minimum 2.

Ports:
- axi_clk  in  1  clock.
- axi_rstn  in  1  asynchronous active-low reset.
- tx_en  in  1  enables transmission; sampled at symbol boundaries.
- sym_valid  in  1  upstream symbol valid.
- sym_ready  out  1  high when the FIFO is not full.
- sym_data  in  4  symbol; [3:2] is the I dibit, [1:0] is the Q dibit.
- mod_valid  out  1  high for every sample while in RUN or UNDERRUN.
- mod_i  out  18  signed I sample, 5Q12.
- mod_q  out  18  signed Q sample, 5Q12.
- underflow  out  1  one-cycle pulse at each boundary where an empty FIFO forces a zero symbol.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, active-low):
  - FIFO emptied; state IDLE; sample counter 0.
  - mod_valid, mod_i, mod_q, underflow and busy are all 0.
  - sym_ready is 1 once reset is released.
- FIFO:
  - Write when sym_valid && sym_ready.
  - sym_ready = !full, registered count based.
  - A simultaneous push and pop on a full FIFO is accepted only if sym_ready was already high in that cycle; no combinational ready from pop.
  - Pointers wrap modulo FIFO_DEPTH.
- Mapping (Gray, per dibit): 00 -> -3*AMP, 01 -> -AMP, 11 -> +AMP, 10 -> +3*AMP. With defaults the levels are -12288, -4096, 4096, 12288.
- Sample counter: counts 0..SPS-1. A symbol boundary is the cycle the counter equals SPS-1, or any cycle in IDLE.
- FSM states:
  - IDLE: outputs 0, mod_valid 0. If tx_en && !empty: pop, load the mapped level into mod_i/mod_q registers, counter <= 0, go to RUN.
  - RUN: hold the levels; mod_valid 1. At the boundary:
    - !empty && tx_en: pop the next symbol; this is seamless, with no gap cycle.
    - empty && tx_en: load 0/0, pulse underflow, go to UNDERRUN.
    - !tx_en: go to IDLE; mod_valid drops the next cycle.
  - UNDERRUN: outputs 0, mod_valid 1, which keeps symbol timing. At the boundary:
    - !empty && tx_en: pop, go to RUN.
    - empty && tx_en: stay, pulse underflow again.
    - !tx_en: go to IDLE.
- tx_en changes mid-symbol: ignored until the boundary. The current symbol always completes its full SPS samples.
- Latency: a symbol written at cycle t into an empty FIFO while IDLE with tx_en=1 appears on mod_i/mod_q with mod_valid=1 at t+2 (FIFO count visible at t+1, output register at t+2).
- Every symbol produces exactly SPS consecutive mod_valid samples.
- All outputs are registered. There is no arithmetic growth, because the levels are constants of 18 bits.
- Mid-operation reset: all outputs clear immediately (async) and FIFO contents are discarded.

Decomposition:
- Package qam_pkg holds:
  - typedef qam_sym_t (logic [3:0]);
  - typedef sample_t (logic signed [17:0]);
  - the FSM enum tx_state_e {IDLE, RUN, UNDERRUN};
  - function gray_dibit_to_level(dibit, amp);
  - constant Q_FRAC = 12.
- One sub-module: qam_sym_fifo (synchronous FIFO, parameter DEPTH, width 4, full/empty/count). The mapper and FSM stay in the top level.

Test Plan:
- Reset then idle: release axi_rstn with tx_en=1 and no symbols -> mod_valid=0, mod_i=mod_q=0, busy=0, sym_ready=1.
- Single symbol: push 4'b1001 at cycle t with tx_en=1 -> from t+2, exactly 20 samples of mod_i=+12288, mod_q=-4096; then underflow pulses once and 20 zero samples follow with mod_valid=1.
- Back-to-back stream: push 0000, 0101, 1111, 1010 with tx_en=1 -> 80 contiguous valid samples with levels (-12288,-12288), (-4096,-4096), (4096,4096), (12288,12288); no gap and no underflow.
- Backpressure: hold tx_en=0 and push 5 symbols -> sym_ready low after the 4th is accepted; the 5th is held. Raise tx_en -> the 5th is accepted as the 1st drains, and the order is preserved.
- tx_en drop mid-symbol: deassert at sample 7 of a symbol -> all 20 samples are still output, then mod_valid=0 and busy=0 the cycle after the boundary.
- Async reset mid-symbol: assert axi_rstn=0 at sample 10 -> outputs are 0 in the same cycle. After release, previously buffered symbols are not transmitted.
